// File: rtl/artemis_sata_oob_ctrl_if.sv
// Signal bundle between the SATA OOB sequencer, the GTP SATA port group and the link layer.
interface artemis_sata_oob_ctrl_if;
    logic        i_enable;
    logic        i_pll_detect_k;
    logic        i_reset_done;
    logic [2:0]  i_rx_status;
    logic        i_rx_elec_idle;
    logic [31:0] i_rx_data;
    logic [3:0]  i_rx_char_is_k;
    logic [31:0] i_user_tx_data;
    logic [3:0]  i_user_tx_char_is_k;
    logic        o_tx_comm_start;
    logic        o_tx_comm_type;
    logic        o_tx_elec_idle;
    logic [31:0] o_tx_data;
    logic [3:0]  o_tx_char_is_k;
    logic        o_linkup;
    logic [3:0]  o_state;
    logic [7:0]  o_retry_count;

    modport master (
        input  i_enable, i_pll_detect_k, i_reset_done, i_rx_status, i_rx_elec_idle,
               i_rx_data, i_rx_char_is_k, i_user_tx_data, i_user_tx_char_is_k,
        output o_tx_comm_start, o_tx_comm_type, o_tx_elec_idle, o_tx_data,
               o_tx_char_is_k, o_linkup, o_state, o_retry_count
    );

    modport slave (
        output i_enable, i_pll_detect_k, i_reset_done, i_rx_status, i_rx_elec_idle,
               i_rx_data, i_rx_char_is_k, i_user_tx_data, i_user_tx_char_is_k,
        input  o_tx_comm_start, o_tx_comm_type, o_tx_elec_idle, o_tx_data,
               o_tx_char_is_k, o_linkup, o_state, o_retry_count
    );
endinterface

// File: rtl/artemis_sata_oob_ctrl.sv
// Host-side SATA OOB / link bring-up sequencer: COMRESET, COMINIT, COMWAKE, D10.2/ALIGN, SYNC.
module artemis_sata_oob_ctrl #(
    parameter int unsigned COMINIT_TIMEOUT = 750000,
    parameter int unsigned ALIGN_TIMEOUT   = 66000,
    parameter int unsigned ALIGN_COUNT     = 3,
    parameter int unsigned IDLE_LOSS       = 1024
) (
    input logic                     clk,
    input logic                     rst,
    artemis_sata_oob_ctrl_if.master bus
);
    localparam int unsigned TIMER_W = 20;
    localparam int unsigned ALIGN_W = 8;
    localparam int unsigned IDLE_W  = $clog2(IDLE_LOSS + 1);

    localparam logic [31:0] ALIGN_WORD = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_WORD  = 32'hB5B5957C;
    localparam logic [31:0] D10_WORD   = 32'h4A4A4A4A;
    localparam logic [3:0]  PRIM_K     = 4'b0001;

    localparam logic [TIMER_W-1:0] COMINIT_LAST = TIMER_W'(COMINIT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ALIGN_LAST   = TIMER_W'(ALIGN_TIMEOUT - 1);
    localparam logic [ALIGN_W-1:0] ALIGN_LAST_N = ALIGN_W'(ALIGN_COUNT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST    = IDLE_W'(IDLE_LOSS - 1);

    typedef enum logic [3:0] {
        S_IDLE               = 4'd0,
        S_WAIT_PLL           = 4'd1,
        S_SEND_COMRESET      = 4'd2,
        S_WAIT_COMRESET_DONE = 4'd3,
        S_WAIT_COMINIT       = 4'd4,
        S_SEND_COMWAKE       = 4'd5,
        S_WAIT_COMWAKE_DONE  = 4'd6,
        S_WAIT_COMWAKE       = 4'd7,
        S_SEND_D10           = 4'd8,
        S_SEND_ALIGN         = 4'd9,
        S_READY              = 4'd10
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ALIGN_W-1:0]   align_cnt_q, align_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [7:0]           retry_q, retry_d;
    logic                 retry_inc;
    logic                 comm_start_q, comm_start_d;
    logic                 comm_type_q, comm_type_d;
    logic                 tx_idle_q, tx_idle_d;
    logic [31:0]          tx_data_q, tx_data_d;
    logic [3:0]           tx_k_q, tx_k_d;
    logic                 linkup_q, linkup_d;
    logic                 link_ok, rx_align, rx_sync;

    assign link_ok  = bus.i_pll_detect_k && bus.i_reset_done;
    assign rx_align = (bus.i_rx_data == ALIGN_WORD) && (bus.i_rx_char_is_k == PRIM_K);
    assign rx_sync  = (bus.i_rx_data == SYNC_WORD) && (bus.i_rx_char_is_k == PRIM_K);

    // Next state, counters and registered-output values
    always_comb begin
        state_d     = state_q;
        retry_inc   = 1'b0;
        align_cnt_d = '0;
        idle_cnt_d  = '0;

        case (state_q)
            S_IDLE:          if (bus.i_enable) state_d = S_WAIT_PLL;
            S_WAIT_PLL:      if (link_ok) state_d = S_SEND_COMRESET;
            S_SEND_COMRESET: state_d = S_WAIT_COMRESET_DONE;
            S_WAIT_COMRESET_DONE: begin
                if (bus.i_rx_status[0]) state_d = S_WAIT_COMINIT;
                else if (timer_q == ALIGN_LAST) begin
                    state_d   = S_SEND_COMRESET;
                    retry_inc = 1'b1;
                end
            end
            S_WAIT_COMINIT: begin
                if (bus.i_rx_status[2]) state_d = S_SEND_COMWAKE;
                else if (timer_q == COMINIT_LAST) begin
                    state_d   = S_SEND_COMRESET;
                    retry_inc = 1'b1;
                end
            end
            S_SEND_COMWAKE: state_d = S_WAIT_COMWAKE_DONE;
            S_WAIT_COMWAKE_DONE: begin
                if (bus.i_rx_status[0]) state_d = S_WAIT_COMWAKE;
                else if (timer_q == ALIGN_LAST) begin
                    state_d   = S_SEND_COMRESET;
                    retry_inc = 1'b1;
                end
            end
            S_WAIT_COMWAKE: begin
                if (bus.i_rx_status[1]) state_d = S_SEND_D10;
                else if (timer_q == ALIGN_LAST) begin
                    state_d   = S_SEND_COMRESET;
                    retry_inc = 1'b1;
                end
            end
            S_SEND_D10: begin
                if (rx_align && align_cnt_q == ALIGN_LAST_N) state_d = S_SEND_ALIGN;
                else begin
                    if (rx_align) align_cnt_d = align_cnt_q + ALIGN_W'(1);
                    if (timer_q == ALIGN_LAST) begin
                        state_d   = S_SEND_COMRESET;
                        retry_inc = 1'b1;
                    end
                end
            end
            S_SEND_ALIGN: begin
                if (rx_sync) state_d = S_READY;
                else if (timer_q == ALIGN_LAST) begin
                    state_d   = S_SEND_COMRESET;
                    retry_inc = 1'b1;
                end
            end
            S_READY: begin
                if (bus.i_rx_status[2]) state_d = S_SEND_COMRESET;
                else if (bus.i_rx_elec_idle) begin
                    if (idle_cnt_q == IDLE_LAST) state_d = S_SEND_COMRESET;
                    else idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q >= S_SEND_COMRESET && !link_ok) begin
            state_d     = S_WAIT_PLL;
            retry_inc   = 1'b0;
            align_cnt_d = '0;
            idle_cnt_d  = '0;
        end
        if (!bus.i_enable) begin
            state_d     = S_IDLE;
            retry_inc   = 1'b0;
            align_cnt_d = '0;
            idle_cnt_d  = '0;
        end

        // D10 -> ALIGN keeps the timer running so both states share one lock budget
        if (state_d != state_q && !(state_q == S_SEND_D10 && state_d == S_SEND_ALIGN))
            timer_d = '0;
        else
            timer_d = timer_q + TIMER_W'(1);

        retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;

        comm_start_d = (state_d == S_SEND_COMRESET) || (state_d == S_SEND_COMWAKE);
        comm_type_d  = (state_d == S_SEND_COMWAKE);
        linkup_d     = (state_d == S_READY);
        tx_idle_d    = 1'b1;
        tx_data_d    = '0;
        tx_k_d       = '0;
        case (state_d)
            S_SEND_D10: begin
                tx_idle_d = 1'b0;
                tx_data_d = D10_WORD;
            end
            S_SEND_ALIGN: begin
                tx_idle_d = 1'b0;
                tx_data_d = ALIGN_WORD;
                tx_k_d    = PRIM_K;
            end
            S_READY: begin
                tx_idle_d = 1'b0;
                tx_data_d = bus.i_user_tx_data;
                tx_k_d    = bus.i_user_tx_char_is_k;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            align_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            retry_q      <= '0;
            comm_start_q <= 1'b0;
            comm_type_q  <= 1'b0;
            tx_idle_q    <= 1'b1;
            tx_data_q    <= '0;
            tx_k_q       <= '0;
            linkup_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            align_cnt_q  <= align_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            retry_q      <= retry_d;
            comm_start_q <= comm_start_d;
            comm_type_q  <= comm_type_d;
            tx_idle_q    <= tx_idle_d;
            tx_data_q    <= tx_data_d;
            tx_k_q       <= tx_k_d;
            linkup_q     <= linkup_d;
        end
    end

    assign bus.o_tx_comm_start = comm_start_q;
    assign bus.o_tx_comm_type  = comm_type_q;
    assign bus.o_tx_elec_idle  = tx_idle_q;
    assign bus.o_tx_data       = tx_data_q;
    assign bus.o_tx_char_is_k  = tx_k_q;
    assign bus.o_linkup        = linkup_q;
    assign bus.o_state         = state_q;
    assign bus.o_retry_count   = retry_q;
endmodule

// File: tb/tb_artemis_sata_oob_ctrl.sv
// Bench for artemis_sata_oob_ctrl: a device model drives OOB responses, a scoreboard checks the state trail.
module tb_artemis_sata_oob_ctrl;
    localparam int unsigned COMINIT_T = 100;
    localparam int unsigned ALIGN_T   = 50;
    localparam int unsigned ALIGN_N   = 3;
    localparam int unsigned IDLE_N    = 1024;

    localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_W  = 32'hB5B5957C;
    localparam logic [31:0] D10_W   = 32'h4A4A4A4A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    artemis_sata_oob_ctrl_if bus ();

    artemis_sata_oob_ctrl #(
        .COMINIT_TIMEOUT(COMINIT_T),
        .ALIGN_TIMEOUT  (ALIGN_T),
        .ALIGN_COUNT    (ALIGN_N),
        .IDLE_LOSS      (IDLE_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int state;
        int retry;
        int dwell;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_retry = 0;
    bit   mon_en = 1'b0;
    int   prev_state = 0;
    int   dwell = 0;
    logic [31:0] user_d_edge;
    logic [3:0]  user_k_edge;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic push(input int s, input int dw);
        exp_t e;
        e.state = s;
        e.retry = exp_retry;
        e.dwell = dw;
        exp_q.push_back(e);
    endtask

    task automatic bump_retry();
        if (exp_retry < 255) exp_retry++;
    endtask

    // One cycle: step to the falling edge and refresh link-layer TX data
    task automatic cyc();
        @(negedge clk);
        bus.i_user_tx_data      = $urandom;
        bus.i_user_tx_char_is_k = 4'($urandom);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (int'(bus.o_state) != s && n < budget) begin
            cyc();
            n++;
        end
        check($sformatf("wait_state_%0d", s), longint'(bus.o_state), s);
    endtask

    task automatic pulse_status(input int b);
        bus.i_rx_status = 3'(1 << b);
        cyc();
        bus.i_rx_status = 3'b000;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k);
        bus.i_rx_data      = d;
        bus.i_rx_char_is_k = k;
        cyc();
    endtask

    // Device side of one bring-up, starting as COMRESET goes out
    task automatic bring_up(input int misses, input bit broken, input int upto);
        logic [31:0] wd[$];
        logic [3:0]  wk[$];
        int junk;
        wait_state(3, 40);
        for (int m = 0; m < misses; m++) begin
            repeat ($urandom_range(1, 6)) cyc();
            push(4, -1);
            pulse_status(0);
            bump_retry();
            push(2, COMINIT_T);
            push(3, -1);
            wait_state(3, COMINIT_T + 20);
        end
        repeat ($urandom_range(1, 6)) cyc();
        push(4, -1);
        pulse_status(0);
        repeat ($urandom_range(1, 20)) cyc();
        push(5, -1);
        push(6, -1);
        pulse_status(2);
        wait_state(6, 10);
        repeat ($urandom_range(1, 6)) cyc();
        push(7, -1);
        pulse_status(0);
        if (upto > 7) begin
            repeat ($urandom_range(1, 20)) cyc();
            push(8, -1);
            pulse_status(1);
            wait_state(8, 10);
            if (broken) begin
                wd = '{ALIGN_W, ALIGN_W, SYNC_W, ALIGN_W, ALIGN_W, ALIGN_W};
                wk = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
            end else begin
                junk = int'($urandom_range(0, 5));
                for (int j = 0; j < junk; j++) begin
                    wd.push_back($urandom);
                    wk.push_back(4'b0000);
                end
                for (int j = 0; j < int'(ALIGN_N); j++) begin
                    wd.push_back(ALIGN_W);
                    wk.push_back(4'b0001);
                end
            end
            push(9, wd.size());
            for (int i = 0; i < wd.size(); i++) begin
                send_word(wd[i], wk[i]);
                if (broken && i == 4) check("broken_align_hold", longint'(bus.o_state), 8);
            end
            repeat ($urandom_range(0, 3)) cyc();
            push(10, -1);
            send_word(SYNC_W, 4'b0001);
            bus.i_rx_data      = 32'h0;
            bus.i_rx_char_is_k = 4'h0;
            check("linkup_up", longint'(bus.o_linkup), 1);
            check("linkup_retry", longint'(bus.o_retry_count), exp_retry);
        end
    endtask

    always @(posedge clk) begin
        user_d_edge <= bus.i_user_tx_data;
        user_k_edge <= bus.i_user_tx_char_is_k;
    end

    // Monitor: output rules every cycle, scoreboard pop on each state change
    always @(negedge clk) begin
        if (mon_en) begin
            int   s;
            exp_t e;
            s = int'(bus.o_state);
            check("mon_linkup", longint'(bus.o_linkup), longint'(s == 10));
            check("mon_tx_idle", longint'(bus.o_tx_elec_idle), longint'(s < 8));
            check("mon_comm_start", longint'(bus.o_tx_comm_start), longint'(s == 2 || s == 5));
            if (bus.o_tx_comm_start) check("mon_comm_type", longint'(bus.o_tx_comm_type), longint'(s == 5));
            if (s < 8) begin
                check("mon_tx_data", longint'(bus.o_tx_data), 0);
                check("mon_tx_k", longint'(bus.o_tx_char_is_k), 0);
            end else if (s == 8) begin
                check("mon_tx_data", longint'(bus.o_tx_data), longint'(D10_W));
                check("mon_tx_k", longint'(bus.o_tx_char_is_k), 0);
            end else if (s == 9) begin
                check("mon_tx_data", longint'(bus.o_tx_data), longint'(ALIGN_W));
                check("mon_tx_k", longint'(bus.o_tx_char_is_k), 1);
            end else begin
                check("mon_tx_data", longint'(bus.o_tx_data), longint'(user_d_edge));
                check("mon_tx_k", longint'(bus.o_tx_char_is_k), longint'(user_k_edge));
            end
            if (s != prev_state) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_state", s, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_state", s, e.state);
                    check("sb_retry", longint'(bus.o_retry_count), e.retry);
                    if (e.dwell >= 0) check("sb_dwell", dwell, e.dwell);
                end
                prev_state = s;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                     = 1'b1;
        bus.i_enable            = 1'b0;
        bus.i_pll_detect_k      = 1'b0;
        bus.i_reset_done        = 1'b0;
        bus.i_rx_status         = 3'b000;
        bus.i_rx_elec_idle      = 1'b0;
        bus.i_rx_data           = 32'h0;
        bus.i_rx_char_is_k      = 4'h0;
        bus.i_user_tx_data      = 32'h0;
        bus.i_user_tx_char_is_k = 4'h0;
        repeat (3) cyc();
        check("rst_state", longint'(bus.o_state), 0);
        check("rst_comm_start", longint'(bus.o_tx_comm_start), 0);
        check("rst_comm_type", longint'(bus.o_tx_comm_type), 0);
        check("rst_tx_idle", longint'(bus.o_tx_elec_idle), 1);
        check("rst_tx_data", longint'(bus.o_tx_data), 0);
        check("rst_tx_k", longint'(bus.o_tx_char_is_k), 0);
        check("rst_linkup", longint'(bus.o_linkup), 0);
        check("rst_retry", longint'(bus.o_retry_count), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Nominal bring-up
        push(1, -1);
        bus.i_enable = 1'b1;
        repeat (3) cyc();
        push(2, -1);
        push(3, -1);
        bus.i_pll_detect_k = 1'b1;
        bus.i_reset_done   = 1'b1;
        bring_up(0, 1'b0, 10);
        repeat (5) cyc();

        // Device COMINIT in READY, then one COMINIT timeout and a broken ALIGN run
        push(2, -1);
        push(3, -1);
        pulse_status(2);
        bring_up(1, 1'b1, 10);

        // Idle burst one short of the loss threshold keeps the link
        bus.i_rx_elec_idle = 1'b1;
        repeat (IDLE_N - 1) cyc();
        bus.i_rx_elec_idle = 1'b0;
        repeat (3) cyc();
        check("idle_short_linkup", longint'(bus.o_linkup), 1);

        push(2, -1);
        push(3, -1);
        bus.i_rx_elec_idle = 1'b1;
        repeat (IDLE_N) cyc();
        bus.i_rx_elec_idle = 1'b0;
        check("idle_loss_state", longint'(bus.o_state), 2);
        check("idle_loss_comreset", longint'(bus.o_tx_comm_start), 1);
        check("idle_loss_linkup", longint'(bus.o_linkup), 0);

        // Disable while waiting for COMWAKE
        bring_up(0, 1'b0, 7);
        check("pre_disable_state", longint'(bus.o_state), 7);
        push(0, -1);
        bus.i_enable = 1'b0;
        cyc();
        check("disable_state", longint'(bus.o_state), 0);
        check("disable_tx_idle", longint'(bus.o_tx_elec_idle), 1);
        check("disable_retry", longint'(bus.o_retry_count), exp_retry);

        // PLL loss mid-sequence returns to WAIT_PLL
        push(1, -1);
        push(2, -1);
        push(3, -1);
        bus.i_enable = 1'b1;
        wait_state(3, 20);
        push(1, -1);
        bus.i_pll_detect_k = 1'b0;
        repeat (3) cyc();
        push(2, -1);
        push(3, -1);
        bus.i_pll_detect_k = 1'b1;
        wait_state(3, 20);

        // Retry saturation through repeated COMRESET-done timeouts
        for (int i = 0; i < 300; i++) begin
            bump_retry();
            push(2, ALIGN_T);
            push(3, -1);
        end
        repeat (300 * (ALIGN_T + 1) + 10) cyc();
        check("retry_saturated", longint'(bus.o_retry_count), 255);
        push(0, -1);
        bus.i_enable = 1'b0;
        repeat (3) cyc();
        check("retry_hold_idle", longint'(bus.o_retry_count), 255);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
